console_writer: RTL and testbench
=================================

CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per text row.
REQ-002 SHALL have parameter ROWS, default 30, text rows on screen; COLS*ROWS SHALL be <= 4096.
REQ-003 SHALL have parameter ATTR, default 8'h07, colour attribute placed in wdata[15:8].
REQ-004 SHALL have port clk  input  1  single clock for all logic, the display write clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  in_data holds a byte to consume.
REQ-007 SHALL have port in_data  input  8  ASCII byte.
REQ-008 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready at a rising edge.
REQ-009 SHALL have port waddr  output  12  text memory word address, row*COLS+col.
REQ-010 SHALL have port wdata  output  16  {ATTR, character code}.
REQ-011 SHALL have port we  output  1  write strobe, one word per cycle while high.

Function
REQ-012 SHALL implement states IDLE, PUT, CLEAR; in_ready SHALL be 1 only in IDLE.
REQ-013 SHALL hold cursor col (0..COLS-1), row (0..ROWS-1) and row base = row*COLS, maintained by add/subtract of COLS (no multiplier).
REQ-014 Printable byte 0x20..0x7E accepted at cycle N: SHALL drive we=1, waddr=base+col, wdata={ATTR,byte} in cycle N+1 (PUT), then advance col.
REQ-015 Advance from col=COLS-1 SHALL set col=0, row=row+1 (ROWS-1 wraps to 0) and enter CLEAR for the new row.
REQ-016 0x0A (LF) SHALL set col=0, advance row with same wrap, and enter CLEAR for the new row; no character write.
REQ-017 0x0D (CR) SHALL set col=0; 0x08 (BS) SHALL decrement col if col>0, else no change; both return to IDLE with we=0.
REQ-018 0x0C (FF) SHALL set col=row=0 and enter CLEAR for the whole screen.
REQ-019 All other bytes SHALL be consumed and ignored, we=0.
REQ-020 CLEAR SHALL write {ATTR,8'h20} with we=1 every cycle to consecutive addresses: row clear = COLS words from new base; screen clear = 0..COLS*ROWS-1; then return to IDLE.
REQ-021 we SHALL be 0 in IDLE; waddr/wdata are don't-care when we=0.
REQ-022 in_valid with in_ready=0 SHALL NOT be consumed; in_data SHALL be sampled only at acceptance.

Reset
REQ-023 reset SHALL set col=0, row=0, base=0, we=0, in_ready=0, then enter screen CLEAR on the first cycle after reset deasserts.
REQ-024 reset asserted mid-PUT or mid-CLEAR SHALL abort it; no further writes of the aborted operation; screen CLEAR restarts from address 0.

Configuration
REQ-025 Macro CONSOLE_CURSOR_EN SHALL enable a visible cursor; absent, no cursor writes occur.
REQ-026 With CONSOLE_CURSOR_EN defined, after every PUT, CLEAR, CR, BS or LF completion the block SHALL spend one extra cycle writing {ATTR,8'h5F} at the new cursor address (we=1) before IDLE, and before moving the cursor SHALL restore the old cell with {ATTR,8'h20} unless the operation overwrites that cell.

Verification
REQ-027 Reset, COLS=80, ROWS=30 -> 2400 writes, addresses 0..2399, data 16'h0720, one per cycle, then in_ready=1.
REQ-028 Send 0x41 at cycle N -> we=1, waddr=0, wdata=16'h0741 at N+1; in_ready=0 at N+1, 1 at N+2.
REQ-029 Send 80 printable bytes -> 80th at waddr 79, then 80 clear writes at 80..159, next byte lands at waddr 80.
REQ-030 Cursor at row 29, send 0x0A -> clear writes at 0..79, next 0x42 written at waddr 0 as 16'h0742.
REQ-031 col=0, send 0x08 then 0x43 -> no write for BS, 0x43 at current base+0; send 0x0C -> 2400 clear writes, cursor 0,0.
REQ-032 Assert reset during row clear -> we=0 next cycle, screen clear restarts at 0; with CONSOLE_CURSOR_EN, 0x41 at 0,0 -> writes 0x0741 at 0 then 0x075F at 1.

Source files
------------

// File: rtl/console_writer.sv
// Text-mode console writer: turns an ASCII byte stream into {attr,char} text-memory writes.
// Optional visible cursor enabled by defining CONSOLE_CURSOR_EN.
module console_writer #(
    parameter int         COLS = 80,
    parameter int         ROWS = 30,
    parameter logic [7:0] ATTR = 8'h07
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [11:0] waddr,
    output logic [15:0] wdata,
    output logic        we
);

    localparam logic [11:0] COLS_W      = 12'(COLS);
    localparam logic [11:0] COLS_M1     = 12'(COLS - 1);
    localparam logic [11:0] ROWS_M1     = 12'(ROWS - 1);
    localparam logic [11:0] SCREEN_LAST = 12'(COLS * ROWS - 1);
    localparam logic [15:0] BLANK       = {ATTR, 8'h20};
    localparam logic [15:0] CURS        = {ATTR, 8'h5F};

    typedef enum logic [2:0] {IDLE, PUT, CLEAR, CURSOR, RESTORE} state_t;

    state_t      state_q, state_d;
    logic [11:0] col_q, col_d;
    logic [11:0] row_q, row_d;
    logic [11:0] base_q, base_d;
    logic [11:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        in_ready_q, in_ready_d;
    logic [11:0] clr_last_q, clr_last_d;
    logic        restore_to_clr_q, restore_to_clr_d;

    logic [11:0] next_row_s;
    logic [11:0] next_base_s;
    logic [11:0] cur_addr_s;

    // Row advance with wrap to the top of the screen; base tracks row*COLS by addition only.
    always_comb begin
        cur_addr_s = base_q + col_q;
        if (row_q == ROWS_M1) begin
            next_row_s  = 12'd0;
            next_base_s = 12'd0;
        end else begin
            next_row_s  = row_q + 12'd1;
            next_base_s = base_q + COLS_W;
        end
    end

    // Next-state and next-output computation for the writer FSM.
    always_comb begin
        state_d          = state_q;
        col_d            = col_q;
        row_d            = row_q;
        base_d           = base_q;
        waddr_d          = waddr_q;
        wdata_d          = wdata_q;
        we_d             = 1'b0;
        clr_last_d       = clr_last_q;
        restore_to_clr_d = restore_to_clr_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    if ((in_data >= 8'h20) && (in_data <= 8'h7E)) begin
                        state_d = PUT;
                        we_d    = 1'b1;
                        waddr_d = cur_addr_s;
                        wdata_d = {ATTR, in_data};
                    end else if (in_data == 8'h0A) begin
                        col_d      = 12'd0;
                        row_d      = next_row_s;
                        base_d     = next_base_s;
                        clr_last_d = next_base_s + COLS_M1;
                        we_d       = 1'b1;
                        wdata_d    = BLANK;
`ifdef CONSOLE_CURSOR_EN
                        state_d          = RESTORE;
                        waddr_d          = cur_addr_s;
                        restore_to_clr_d = 1'b1;
`else
                        state_d          = CLEAR;
                        waddr_d          = next_base_s;
`endif
                    end else if ((in_data == 8'h0D) || (in_data == 8'h08)) begin
                        if (in_data == 8'h0D) begin
                            col_d = 12'd0;
                        end else if (col_q != 12'd0) begin
                            col_d = col_q - 12'd1;
                        end else begin
                            col_d = col_q;
                        end
`ifdef CONSOLE_CURSOR_EN
                        we_d = 1'b1;
                        // The old cell only needs repainting if the cursor actually leaves it.
                        if (col_d != col_q) begin
                            state_d          = RESTORE;
                            waddr_d          = cur_addr_s;
                            wdata_d          = BLANK;
                            restore_to_clr_d = 1'b0;
                        end else begin
                            state_d = CURSOR;
                            waddr_d = base_q + col_d;
                            wdata_d = CURS;
                        end
`endif
                    end else if (in_data == 8'h0C) begin
                        col_d      = 12'd0;
                        row_d      = 12'd0;
                        base_d     = 12'd0;
                        clr_last_d = SCREEN_LAST;
                        state_d    = CLEAR;
                        we_d       = 1'b1;
                        waddr_d    = 12'd0;
                        wdata_d    = BLANK;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PUT: begin
                if (col_q == COLS_M1) begin
                    col_d      = 12'd0;
                    row_d      = next_row_s;
                    base_d     = next_base_s;
                    clr_last_d = next_base_s + COLS_M1;
                    state_d    = CLEAR;
                    we_d       = 1'b1;
                    waddr_d    = next_base_s;
                    wdata_d    = BLANK;
                end else begin
                    col_d = col_q + 12'd1;
`ifdef CONSOLE_CURSOR_EN
                    state_d = CURSOR;
                    we_d    = 1'b1;
                    waddr_d = cur_addr_s + 12'd1;
                    wdata_d = CURS;
`else
                    state_d = IDLE;
`endif
                end
            end
            CLEAR: begin
                // After reset CLEAR is entered with we low; the first cycle only raises it.
                if (!we_q) begin
                    we_d = 1'b1;
                end else if (waddr_q == clr_last_q) begin
`ifdef CONSOLE_CURSOR_EN
                    state_d = CURSOR;
                    we_d    = 1'b1;
                    waddr_d = cur_addr_s;
                    wdata_d = CURS;
`else
                    state_d = IDLE;
`endif
                end else begin
                    we_d    = 1'b1;
                    waddr_d = waddr_q + 12'd1;
                end
            end
            CURSOR: begin
                state_d = IDLE;
            end
            RESTORE: begin
                we_d = 1'b1;
                if (restore_to_clr_q) begin
                    state_d = CLEAR;
                    waddr_d = base_q;
                    wdata_d = BLANK;
                end else begin
                    state_d = CURSOR;
                    waddr_d = cur_addr_s;
                    wdata_d = CURS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and registered outputs; reset arms a full-screen clear starting at address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= CLEAR;
            col_q            <= 12'd0;
            row_q            <= 12'd0;
            base_q           <= 12'd0;
            waddr_q          <= 12'd0;
            wdata_q          <= BLANK;
            we_q             <= 1'b0;
            in_ready_q       <= 1'b0;
            clr_last_q       <= SCREEN_LAST;
            restore_to_clr_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            col_q            <= col_d;
            row_q            <= row_d;
            base_q           <= base_d;
            waddr_q          <= waddr_d;
            wdata_q          <= wdata_d;
            we_q             <= we_d;
            in_ready_q       <= in_ready_d;
            clr_last_q       <= clr_last_d;
            restore_to_clr_q <= restore_to_clr_d;
        end
    end

    assign in_ready = in_ready_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign we       = we_q;

endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer: a cursor/row model queues expected writes, a monitor pops them.
module tb_console_writer;

    localparam int         COLS = 80;
    localparam int         ROWS = 30;
    localparam logic [7:0] ATTR = 8'h07;
`ifdef CONSOLE_CURSOR_EN
    localparam bit CUR = 1'b1;
`else
    localparam bit CUR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [11:0] waddr;
    logic [15:0] wdata;
    logic        we;

    int tests_run = 0;
    int tests_failed = 0;
    logic [27:0] exp_q[$];
    logic [27:0] mon_e;
    int m_col = 0;
    int m_row = 0;

    console_writer #(.COLS(COLS), .ROWS(ROWS), .ATTR(ATTR)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .waddr(waddr), .wdata(wdata), .we(we)
    );

    always #5 clk = ~clk;

    // Every observed write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL write_unexpected: got addr %0d data %h, no write expected", waddr, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({waddr, wdata} !== mon_e) begin
                    tests_failed++;
                    $display("FAIL write_data: got addr %0d data %h, expected addr %0d data %h",
                             waddr, wdata, mon_e[27:16], mon_e[15:0]);
                end
            end
        end
    end

    task automatic push(input int a, input logic [7:0] ch);
        exp_q.push_back({12'(a), ATTR, ch});
    endtask

    task automatic m_clear(input int start, input int n);
        for (int i = 0; i < n; i++) push(start + i, 8'h20);
    endtask

    task automatic m_cursor();
        if (CUR) push(m_row * COLS + m_col, 8'h5F);
    endtask

    task automatic m_newline();
        m_col = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        m_clear(m_row * COLS, COLS);
        m_cursor();
    endtask

    task automatic m_reset();
        m_col = 0;
        m_row = 0;
        m_clear(0, COLS * ROWS);
        m_cursor();
    endtask

    task automatic m_byte(input logic [7:0] b);
        int old;
        if (b >= 8'h20 && b <= 8'h7E) begin
            push(m_row * COLS + m_col, b);
            if (m_col == COLS - 1) m_newline();
            else begin
                m_col++;
                m_cursor();
            end
        end else if (b == 8'h0A) begin
            if (CUR) push(m_row * COLS + m_col, 8'h20);
            m_newline();
        end else if (b == 8'h0D || b == 8'h08) begin
            old = m_col;
            if (b == 8'h0D) m_col = 0;
            else if (m_col > 0) m_col--;
            if (CUR && old != m_col) push(m_row * COLS + old, 8'h20);
            m_cursor();
        end else if (b == 8'h0C) begin
            m_reset();
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (in_ready !== 1'b1 && n < 10000);
        if (in_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        in_valid = 1'b1;
        in_data  = b;
        m_byte(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic check_drain(input string name);
        wait_ready();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s: %0d expected writes missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int cnt = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (we !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: we=%b in_ready=%b, expected 0 0", we, in_ready);
        end
        exp_q.delete();
        m_reset();
        reset = 1'b0;
        while (in_ready !== 1'b1 && cnt < 6000) begin
            @(negedge clk);
            cnt++;
        end
        tests_run++;
        if (cnt != COLS * ROWS + 1 + int'(CUR)) begin
            tests_failed++;
            $display("FAIL reset_clear_len: ready after %0d cycles, expected %0d", cnt, COLS * ROWS + 1 + int'(CUR));
        end
        check_drain("reset_clear_drain");
    endtask

    task automatic test_put();
        send_byte(8'h41);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || we !== 1'b1) begin
            tests_failed++;
            $display("FAIL put_n1: in_ready=%b we=%b, expected 0 1", in_ready, we);
        end
        @(negedge clk);
        tests_run++;
        if (in_ready !== !CUR) begin
            tests_failed++;
            $display("FAIL put_n2_ready: in_ready=%b, expected %b", in_ready, !CUR);
        end
        check_drain("put_drain");
    endtask

    task automatic test_row_wrap();
        send_byte(8'h0D);
        for (int i = 0; i < COLS; i++) send_byte(8'(8'h20 + (i % 95)));
        send_byte(8'h51);
        check_drain("row_wrap_drain");
    endtask

    task automatic test_lf_last_row();
        send_byte(8'h0C);
        for (int i = 0; i < ROWS; i++) send_byte(8'h0A);
        send_byte(8'h42);
        check_drain("lf_last_row_drain");
    endtask

    task automatic test_bs_cr();
        send_byte(8'h0D);
        send_byte(8'h08);
        send_byte(8'h43);
        send_byte(8'h44);
        send_byte(8'h08);
        send_byte(8'h08);
        send_byte(8'h08);
        send_byte(8'h45);
        check_drain("bs_cr_drain");
    endtask

    task automatic test_ignored();
        logic [7:0] junk[6];
        junk = '{8'h00, 8'h7F, 8'h1B, 8'h80, 8'hFF, 8'h09};
        for (int i = 0; i < 6; i++) send_byte(junk[i]);
        send_byte(8'h5A);
        check_drain("ignored_drain");
    endtask

    task automatic test_not_ready();
        send_byte(8'h0C);
        in_valid = 1'b1;
        in_data  = 8'h58;
        repeat (200) @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ready: in_ready=%b during clear, expected 0", in_ready);
        end
        in_valid = 1'b0;
        check_drain("not_ready_drain");
    endtask

    task automatic test_reset_mid_clear();
        send_byte(8'h0A);
        repeat (10) @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (we !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_we: we=%b after reset, expected 0", we);
        end
        exp_q.delete();
        m_reset();
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (we !== 1'b1 || waddr !== 12'd0) begin
            tests_failed++;
            $display("FAIL restart_addr: we=%b waddr=%0d, expected 1 0", we, waddr);
        end
        check_drain("reset_mid_clear_drain");
        send_byte(8'h41);
        check_drain("post_reset_put_drain");
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) send_byte(8'($urandom_range(32, 126)));
            else if (r < 80) send_byte(8'h0A);
            else if (r < 87) send_byte(8'h0D);
            else if (r < 95) send_byte(8'h08);
            else send_byte(8'h01);
        end
        check_drain("random_drain");
    endtask

    initial begin
        test_reset();
        test_put();
        test_row_wrap();
        test_bs_cr();
        test_ignored();
        test_lf_last_row();
        test_not_ready();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
